rf_wb_sched: RTL and testbench

- Write-back scheduler for the 32x32 register file, which has a single write port.
- Arbitrates NREQ write-back requesters (ALU, load unit, mul/div) onto that port using round-robin and a valid/ready handshake.
- Keeps a busy scoreboard of destination registers with writes still in flight, so the issue stage can stall on RAW hazards.
- Sits between the execute-side producers and the RF write inputs (WE, wR, WD).

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_wb_sched_if.sv | 47 ++++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/rf_wb_sched.sv | 121 ++++++++++++
 tb/tb_rf_wb_sched.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared constants and types for the register-file write-back
//                scheduler: data width, register address width, register
//                count and the x0 address.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int RAW      = 5;
    localparam int NUM_REGS = 32;

    typedef logic [RAW-1:0]  reg_addr_t;
    typedef logic [XLEN-1:0] xdata_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wb_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_sched_if
//  Description : Bundle of every non-clock signal of the write-back
//                scheduler.
//                  req_valid/req_rd/req_data/req_ready : producer handshake
//                  rf_we/rf_wr/rf_wd                   : RF write port
//                  iss_valid/iss_rd                    : issue-side set
//                  chk_rs1/chk_rs2/rs1_busy/rs2_busy   : RAW hazard lookup
//                  busy_vec                            : raw scoreboard
//                slave  = scheduler side, master = producer/issue side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_sched_if
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = rf_pkg::XLEN,
    parameter int RAW  = rf_pkg::RAW
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*RAW-1:0]  req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [RAW-1:0]       rf_wr;
    logic [XLEN-1:0]      rf_wd;
    logic                 iss_valid;
    logic [RAW-1:0]       iss_rd;
    logic [RAW-1:0]       chk_rs1;
    logic [RAW-1:0]       chk_rs2;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic [NUM_REGS-1:0]  busy_vec;

    modport slave (
        input  req_valid, req_rd, req_data, iss_valid, iss_rd, chk_rs1, chk_rs2,
        output req_ready, rf_we, rf_wr, rf_wd, rs1_busy, rs2_busy, busy_vec
    );

    modport master (
        output req_valid, req_rd, req_data, iss_valid, iss_rd, chk_rs1, chk_rs2,
        input  req_ready, rf_we, rf_wr, rf_wd, rs1_busy, rs2_busy, busy_vec
    );

endinterface : rf_wb_sched_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter with a one-hot combinational grant.
//                The search starts one past the last granted index; the
//                pointer moves to the granted index only when advance is set.
//  Ports       : clk, rst_n (async, active low), req[N], grant[N] (one-hot),
//                advance (a grant was consumed this cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [N-1:0] req,
    input  wire logic         advance,
    output logic      [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;

    always_comb begin
        logic          w_found;
        grant   = '0;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int            c;
            logic [PW-1:0] cand;
            c = int'(r_ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            cand = c[PW-1:0];
            if (!w_found && req[cand]) begin
                grant[cand] = 1'b1;
                w_idx       = cand;
                w_found     = 1'b1;
            end
        end
    end

    // Reset to N-1 so that requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PW'(N - 1);
        end else if (advance) begin
            r_ptr <= w_idx;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rf_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_sched
//  Description : Write-back scheduler for the single-write-port 32x32 RF.
//                Round-robin arbitrates NREQ producers onto the RF write port
//                (1-cycle latency, 1 write/cycle, writes to x0 are consumed
//                but suppressed) and keeps a busy scoreboard of destination
//                registers with writes in flight for RAW stall detection.
//  Ports       : clk, rst_n (async, active low), bus (rf_wb_sched_if.slave).
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_sched
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = rf_pkg::XLEN,
    parameter int RAW  = rf_pkg::RAW
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    rf_wb_sched_if.slave  bus
);
    logic [NREQ-1:0]     w_grant;
    logic                w_fire;
    logic [RAW-1:0]      w_sel_rd;
    logic [XLEN-1:0]     w_sel_data;

    logic                r_we;
    logic [RAW-1:0]      r_wr;
    logic [XLEN-1:0]     r_wd;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // ------------------------------------------------------------------
    // Arbitration: the RF never back-pressures, so a grant is a transfer
    // whenever the granted requester is valid (which it always is).
    // ------------------------------------------------------------------
    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (w_fire),
        .grant   (w_grant)
    );

    assign w_fire = |(bus.req_valid & w_grant);

    // One-hot AND-OR mux of the granted requester's address and data.
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = w_sel_rd   | bus.req_rd[i*RAW +: RAW];
                w_sel_data = w_sel_data | bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write register: address/data hold when idle; we only pulses for a
    // transfer to a non-zero destination.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
            r_wr <= '0;
            r_wd <= '0;
        end else if (w_fire) begin
            r_we <= (w_sel_rd != REG_ZERO);
            r_wr <= w_sel_rd;
            r_wd <= w_sel_data;
        end else begin
            r_we <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard. The clear is applied before the set so that a newly
    // issued producer to the register being written keeps it busy.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_wr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != REG_ZERO)) begin
            w_busy_nxt[bus.iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. No bypass: a register being written this cycle still reads
    // busy, since the RF only captures the value at the next edge.
    // ------------------------------------------------------------------
    assign bus.req_ready = w_grant;
    assign bus.rf_we     = r_we;
    assign bus.rf_wr     = r_wr;
    assign bus.rf_wd     = r_wd;
    assign bus.busy_vec  = r_busy;
    assign bus.rs1_busy  = r_busy[bus.chk_rs1] & (bus.chk_rs1 != REG_ZERO);
    assign bus.rs2_busy  = r_busy[bus.chk_rs2] & (bus.chk_rs2 != REG_ZERO);

    // Issue must never dispatch a second producer to a busy register.
    a_no_waw : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.iss_valid && r_busy[bus.iss_rd]));

endmodule : rf_wb_sched
`default_nettype wire

// File: tb/tb_rf_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_sched
//  Description : Self-checking bench for rf_wb_sched. Directed scenarios with
//                literal expectations, followed by randomized traffic. A
//                behavioural model (last-granted index, expected write,
//                busy bit array) is compared with the DUT on every falling
//                edge while out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_sched;
    import rf_pkg::*;

    localparam int NREQ = 2;

    logic clk;
    logic rst_n;

    rf_wb_sched_if #(.NREQ(NREQ), .XLEN(XLEN), .RAW(RAW)) bus ();

    rf_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .RAW(RAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int          m_last;     // index granted most recently
    bit          m_we;
    bit [4:0]    m_wr;
    bit [31:0]   m_wd;
    bit [31:0]   m_busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_last = NREQ - 1;
            m_we   = 0;
            m_wr   = 0;
            m_wd   = 0;
            m_busy = 0;
        end else begin
            int          gi;
            logic [NREQ-1:0] exp_ready;
            bit [31:0]   nb;
            bit [4:0]    rd;

            // Who should win: first valid requester after the last winner.
            gi = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_last + k) % NREQ;
                if (gi < 0 && bus.req_valid[idx]) gi = idx;
            end
            exp_ready = '0;
            if (gi >= 0) exp_ready[gi] = 1'b1;

            check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            check("rf_we",     64'(bus.rf_we),     64'(m_we));
            check("rf_wr",     64'(bus.rf_wr),     64'(m_wr));
            check("rf_wd",     64'(bus.rf_wd),     64'(m_wd));
            check("busy_vec",  64'(bus.busy_vec),  64'(m_busy));
            check("rs1_busy",  64'(bus.rs1_busy),
                  64'(bus.chk_rs1 != 0 && m_busy[bus.chk_rs1]));
            check("rs2_busy",  64'(bus.rs2_busy),
                  64'(bus.chk_rs2 != 0 && m_busy[bus.chk_rs2]));

            // Next state: the write in flight this cycle retires first,
            // then a new issue marks its destination.
            nb = m_busy;
            if (m_we) nb[m_wr] = 0;
            if (bus.iss_valid && bus.iss_rd != 0) nb[bus.iss_rd] = 1;
            m_busy = nb;

            if (gi >= 0) begin
                rd     = bus.req_rd[gi*RAW +: RAW];
                m_last = gi;
                m_we   = (rd != 0);
                m_wr   = rd;
                m_wd   = bus.req_data[gi*XLEN +: XLEN];
            end else begin
                m_we = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.chk_rs1   = '0;
        bus.chk_rs2   = '0;
    endtask

    logic [NREQ-1:0] fired;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Idle after reset
        #1;
        check("idle rf_we",     64'(bus.rf_we),     64'd0);
        check("idle busy_vec",  64'(bus.busy_vec),  64'd0);
        check("idle req_ready", 64'(bus.req_ready), 64'd0);
        tick();

        // Single write from requester 0
        bus.req_valid = 2'b01;
        bus.req_rd[0*RAW +: RAW]    = 5'd5;
        bus.req_data[0*XLEN +: XLEN] = 32'hDEADBEEF;
        #1 check("single ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = '0;
        check("single rf_we", 64'(bus.rf_we), 64'd1);
        check("single rf_wr", 64'(bus.rf_wr), 64'd5);
        check("single rf_wd", 64'(bus.rf_wd), 64'hDEADBEEF);
        tick();

        // x0 destination from requester 1: consumed, not written
        bus.req_valid = 2'b10;
        bus.req_rd[1*RAW +: RAW]    = 5'd0;
        bus.req_data[1*XLEN +: XLEN] = 32'h1234;
        #1 check("x0 ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = '0;
        check("x0 rf_we",    64'(bus.rf_we),    64'd0);
        check("x0 busy_vec", 64'(bus.busy_vec), 64'd0);
        tick();

        // Contention: grants alternate starting with requester 0
        bus.req_rd[0*RAW +: RAW]     = 5'd3;
        bus.req_rd[1*RAW +: RAW]     = 5'd7;
        bus.req_data[0*XLEN +: XLEN] = 32'hA0A0A0A0;
        bus.req_data[1*XLEN +: XLEN] = 32'hB1B1B1B1;
        bus.req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1 check("cont ready", 64'(bus.req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            check("cont rf_we", 64'(bus.rf_we), 64'd1);
            check("cont rf_wr", 64'(bus.rf_wr), (c % 2 == 0) ? 64'd3 : 64'd7);
        end
        bus.req_valid = '0;
        tick();

        // Scoreboard set, no-bypass, clear
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        tick();
        bus.iss_valid = 1'b0;
        bus.chk_rs1   = 5'd9;
        #1;
        check("sb set bit9",  64'(bus.busy_vec[9]), 64'd1);
        check("sb rs1_busy",  64'(bus.rs1_busy),    64'd1);
        bus.req_valid = 2'b01;
        bus.req_rd[0*RAW +: RAW]     = 5'd9;
        bus.req_data[0*XLEN +: XLEN] = 32'h00000055;
        tick();
        bus.req_valid = '0;
        #1;
        check("sb wb rf_wr",    64'(bus.rf_wr),       64'd9);
        check("sb nobypass",    64'(bus.busy_vec[9]), 64'd1);
        check("sb nobypass rs", 64'(bus.rs1_busy),    64'd1);
        tick();
        #1;
        check("sb clr bit9", 64'(bus.busy_vec[9]), 64'd0);
        check("sb clr rs1",  64'(bus.rs1_busy),    64'd0);
        bus.chk_rs1 = 5'd0;
        #1 check("sb rs1 x0", 64'(bus.rs1_busy), 64'd0);
        tick();

        // Set/clear collision on register 12: set wins
        bus.req_valid = 2'b10;
        bus.req_rd[1*RAW +: RAW]     = 5'd12;
        bus.req_data[1*XLEN +: XLEN] = 32'hC0FFEE00;
        tick();
        bus.req_valid = '0;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd12;
        #1;
        check("coll rf_we", 64'(bus.rf_we), 64'd1);
        check("coll rf_wr", 64'(bus.rf_wr), 64'd12);
        tick();
        bus.iss_valid = 1'b0;
        #1 check("coll bit12", 64'(bus.busy_vec[12]), 64'd1);
        tick();

        // Asynchronous reset while a write is on the port
        bus.req_valid = 2'b01;
        bus.req_rd[0*RAW +: RAW]     = 5'd20;
        bus.req_data[0*XLEN +: XLEN] = 32'h77777777;
        tick();
        bus.req_valid = '0;
        #1 check("pre-rst rf_we", 64'(bus.rf_we), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async rst rf_we",    64'(bus.rf_we),    64'd0);
        check("async rst busy_vec", 64'(bus.busy_vec), 64'd0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        tick();

        // Randomized traffic
        fired = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (fired[i] || !bus.req_valid[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    bus.req_rd[i*RAW +: RAW]     = 5'($urandom_range(0, 31));
                    bus.req_data[i*XLEN +: XLEN] = $urandom;
                end
            end
            begin
                int r;
                r = $urandom_range(0, 31);
                bus.iss_rd    = 5'(r);
                bus.iss_valid = ($urandom_range(0, 1) == 1) && !(r != 0 && m_busy[r]);
            end
            bus.chk_rs1 = 5'($urandom_range(0, 31));
            bus.chk_rs2 = 5'($urandom_range(0, 31));
            #3 fired = bus.req_valid & bus.req_ready;
            tick();
        end

        clear_inputs();
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rf_wb_sched
`default_nettype wire
